// File: rtl/instr_sequencer.sv
// Programmable instruction-address sequencer: replays (address, dwell) entries
// into the MIPS core after a reset pulse, once or in a loop.
module instr_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 4,
    parameter int RST_CYC = 2,
    parameter int PASS_W  = 8,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [IDX_W:0]    len,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] cur_add,
    output logic              cur_valid,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  step_idx,
    output logic [PASS_W-1:0] pass_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RST_HOLD, S_RUN, S_DONE} state_t;

    localparam int HOLD_W = (RST_CYC > 2) ? $clog2(RST_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYC - 1);
    localparam logic [IDX_W:0]    LEN_MAX   = (IDX_W + 1)'(DEPTH);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   mem_addr  [DEPTH];
    logic [DWELL_W-1:0]  mem_dwell [DEPTH];
    logic [HOLD_W-1:0]   hold_cnt, hold_d;
    logic [DWELL_W-1:0]  dwell_cnt, dwell_d;
    logic [IDX_W:0]      len_q, len_d, len_clamped;
    logic                loop_q, loop_d;
    logic [ADDR_W-1:0]   cur_add_d;
    logic                cur_valid_d, core_rst_d, busy_d, done_d;
    logic [IDX_W-1:0]    step_idx_d, idx_inc;
    logic [PASS_W-1:0]   pass_d;
    logic                cfg_open, last_entry;

    assign cfg_open   = (state == S_IDLE) || (state == S_DONE);
    assign idx_inc    = step_idx + 1'b1;
    assign last_entry = ({1'b0, step_idx} == (len_q - 1'b1));

    always_comb begin
        if (len == '0)          len_clamped = (IDX_W + 1)'(1);
        else if (len > LEN_MAX) len_clamped = LEN_MAX;
        else                    len_clamped = len;
    end

    // NOTE: program memory is reset explicitly so a replay right after rst
    // presents zeros instead of entries left over from the previous program.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i]  <= '0;
                mem_dwell[i] <= '0;
            end
        end else if (cfg_we && cfg_open) begin
            mem_addr[cfg_idx]  <= cfg_addr;
            mem_dwell[cfg_idx] <= cfg_dwell;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to "hold" first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d     = state;
        hold_d      = hold_cnt;
        dwell_d     = dwell_cnt;
        len_d       = len_q;
        loop_d      = loop_q;
        cur_add_d   = cur_add;
        cur_valid_d = cur_valid;
        core_rst_d  = core_rst;
        busy_d      = busy;
        done_d      = done;
        step_idx_d  = step_idx;
        pass_d      = pass_cnt;

        case (state)
            S_IDLE, S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end else if (start) begin
                    state_d     = S_RST_HOLD;
                    len_d       = len_clamped;
                    loop_d      = loop_en;
                    done_d      = 1'b0;
                    pass_d      = '0;
                    hold_d      = HOLD_INIT;
                    core_rst_d  = 1'b1;
                    busy_d      = 1'b1;
                    cur_valid_d = 1'b0;
                end
            end
            S_RST_HOLD: begin
                if (stop) begin
                    state_d     = S_IDLE;
                    core_rst_d  = 1'b0;
                    cur_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else if (hold_cnt == '0) begin
                    state_d     = S_RUN;
                    step_idx_d  = '0;
                    cur_add_d   = mem_addr[0];
                    dwell_d     = mem_dwell[0];
                    core_rst_d  = 1'b0;
                    cur_valid_d = 1'b1;
                end else begin
                    hold_d = hold_cnt - 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d     = S_IDLE;
                    core_rst_d  = 1'b0;
                    cur_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else if (dwell_cnt != '0) begin
                    dwell_d = dwell_cnt - 1'b1;
                end else if (!last_entry) begin
                    step_idx_d = idx_inc;
                    cur_add_d  = mem_addr[idx_inc];
                    dwell_d    = mem_dwell[idx_inc];
                end else begin
                    if (pass_cnt != '1) pass_d = pass_cnt + 1'b1;
                    if (loop_q) begin
                        // Wrap straight back to entry 0; the core is not reset again.
                        step_idx_d = '0;
                        cur_add_d  = mem_addr[0];
                        dwell_d    = mem_dwell[0];
                    end else begin
                        state_d     = S_DONE;
                        cur_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            dwell_cnt <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            cur_add   <= '0;
            cur_valid <= 1'b0;
            core_rst  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
            pass_cnt  <= '0;
        end else begin
            state     <= state_d;
            hold_cnt  <= hold_d;
            dwell_cnt <= dwell_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            cur_add   <= cur_add_d;
            cur_valid <= cur_valid_d;
            core_rst  <= core_rst_d;
            busy      <= busy_d;
            done      <= done_d;
            step_idx  <= step_idx_d;
            pass_cnt  <= pass_d;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues the expected address
// stream, a negedge monitor pops it whenever cur_valid is high.
module tb_instr_sequencer;

    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 8;
    localparam int DWELL_W = 4;
    localparam int RST_CYC = 2;
    localparam int PASS_W  = 8;
    localparam int IDX_W   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [IDX_W:0]     len;
    logic               loop_en;
    logic               start;
    logic               stop;
    logic [ADDR_W-1:0]  cur_add;
    logic               cur_valid;
    logic               core_rst;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   step_idx;
    logic [PASS_W-1:0]  pass_cnt;

    always #5 clk = ~clk;

    instr_sequencer #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DWELL_W(DWELL_W),
        .RST_CYC(RST_CYC), .PASS_W(PASS_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_dwell(cfg_dwell), .len(len),
        .loop_en(loop_en), .start(start), .stop(stop), .cur_add(cur_add),
        .cur_valid(cur_valid), .core_rst(core_rst), .busy(busy), .done(done),
        .step_idx(step_idx), .pass_cnt(pass_cnt)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [IDX_W-1:0]  idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each live cycle must match the next queued entry, with core_rst low.
    always @(negedge clk) begin
        exp_t e;
        if (cur_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL stream: unexpected cur_add 0x%0h idx %0d", cur_add, step_idx);
            end else begin
                e = exp_q.pop_front();
                check("stream", {core_rst, cur_add, step_idx}, {1'b0, e.addr, e.idx});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int i, input int a, input int d);
        cfg_we    = 1'b1;
        cfg_idx   = IDX_W'(i);
        cfg_addr  = ADDR_W'(a);
        cfg_dwell = DWELL_W'(d);
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic expect_entry(input int a, input int i, input int cycles);
        exp_t e;
        e.addr = ADDR_W'(a);
        e.idx  = IDX_W'(i);
        repeat (cycles) exp_q.push_back(e);
    endtask

    task automatic expect_prog3(input int first_addr);
        expect_entry(first_addr, 0, 4);
        expect_entry(0, 1, 4);
        expect_entry(1, 2, 2);
    endtask

    // Leaves the bench just after the edge that shows the first RUN cycle.
    task automatic launch(input int l, input bit lp);
        len     = (IDX_W + 1)'(l);
        loop_en = lp;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
        check("hold1_core_rst", core_rst, 1);
        check("hold1_busy", busy, 1);
        check("hold1_valid", cur_valid, 0);
        tick(1);
        check("hold2_core_rst", core_rst, 1);
        tick(1);
        check("run_core_rst", core_rst, 0);
        check("run_valid", cur_valid, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cur_add"}, cur_add, 0);
        check({tag, "_cur_valid"}, cur_valid, 0);
        check({tag, "_core_rst"}, core_rst, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_step_idx"}, step_idx, 0);
        check({tag, "_pass_cnt"}, pass_cnt, 0);
    endtask

    task automatic check_done(input int pc, input int a, input int i);
        check("done_flag", done, 1);
        check("done_busy", busy, 0);
        check("done_valid", cur_valid, 0);
        check("done_pass_cnt", pass_cnt, pc);
        check("done_cur_add", cur_add, a);
        check("done_step_idx", step_idx, i);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_stopped(input int pc, input int i);
        check("stop_valid", cur_valid, 0);
        check("stop_busy", busy, 0);
        check("stop_core_rst", core_rst, 0);
        check("stop_done", done, 0);
        check("stop_pass_cnt", pass_cnt, pc);
        check("stop_cur_add", cur_add, 0);
        check("stop_step_idx", step_idx, i);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_dwell = '0;
        len = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        tick(2);
        rst = 1'b0;
        check_reset_vals("reset");

        write_entry(0, 2, 3);
        write_entry(1, 0, 3);
        write_entry(2, 1, 1);

        // Single pass: 2 x4, 0 x4, 1 x2, then DONE.
        expect_prog3(2);
        launch(3, 0);
        tick(10);
        check_done(1, 1, 2);

        // Looping: 25 RUN cycles of the 10-cycle pattern, then stop.
        for (int c = 0; c < 25; c++) begin
            if (c % 10 < 4)      expect_entry(2, 0, 1);
            else if (c % 10 < 8) expect_entry(0, 1, 1);
            else                 expect_entry(1, 2, 1);
        end
        launch(3, 1);
        tick(19);
        check("loop_pass_c20", pass_cnt, 1);
        tick(1);
        check("loop_pass_c21", pass_cnt, 2);
        check("loop_busy", busy, 1);
        tick(4);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check_stopped(2, 1);

        // Stop in the 3rd cycle of entry 1.
        expect_entry(2, 0, 4);
        expect_entry(0, 1, 3);
        launch(3, 0);
        tick(6);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check_stopped(0, 1);
        tick(2);
        check("stop_stays_idle", busy, 0);

        // A write while running is dropped; the same write in DONE lands.
        expect_prog3(2);
        launch(3, 0);
        write_entry(0, 7, 3);
        tick(9);
        check_done(1, 1, 2);
        expect_prog3(2);
        launch(3, 0);
        tick(10);
        check_done(1, 1, 2);
        write_entry(0, 7, 3);
        expect_prog3(7);
        launch(3, 0);
        tick(10);
        check_done(1, 1, 2);

        // len=0 behaves as a single entry.
        expect_entry(7, 0, 4);
        launch(0, 0);
        tick(4);
        check_done(1, 7, 0);

        // len=15 clamps to all 8 entries.
        for (int i = 0; i < DEPTH; i++) write_entry(i, 16 + i, 0);
        for (int i = 0; i < DEPTH; i++) expect_entry(16 + i, i, 1);
        launch(15, 0);
        tick(8);
        check_done(1, 23, 7);

        // stop in DONE clears done; start with stop in IDLE stays idle.
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("done_cleared_by_stop", done, 0);
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        check("start_stop_busy", busy, 0);
        check("start_stop_core_rst", core_rst, 0);
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_still_idle", busy, 0);

        // rst during RST_HOLD.
        len   = 1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("pre_rst_hold", core_rst, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset_vals("rst_hold");

        // rst during RUN, then a readback run must see cleared memory.
        write_entry(0, 9, 5);
        expect_entry(9, 0, 1);
        launch(1, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset_vals("rst_run");
        expect_entry(0, 0, 1);
        launch(1, 0);
        tick(1);
        check_done(1, 0, 0);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
